// File: rtl/run_seq_pkg.sv
// Shared types and default sizing for the run sequencer.
package run_seq_pkg;

  localparam int unsigned DefAw     = 8;
  localparam int unsigned DefCw     = 16;
  localparam int unsigned DefMaxCyc = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StErr
  } seq_state_t;

endpackage

// File: rtl/run_seq_if.sv
// Host, core and data-memory signals of the run sequencer.
// The master modport is the sequencer side; slave is the host/core/memory side.
interface run_seq_if import run_seq_pkg::*; #(
  parameter int unsigned AW = DefAw,
  parameter int unsigned CW = DefCw
) ();

  logic          start;
  logic [AW:0]   ld_count;
  logic [AW-1:0] rs_base;
  logic [AW:0]   rs_count;
  logic          ld_valid;
  logic          ld_ready;
  logic [7:0]    ld_data;
  logic          rs_valid;
  logic          rs_ready;
  logic [7:0]    rs_data;
  logic          core_reset;
  logic          core_done;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdat;
  logic          mem_we;
  logic [7:0]    mem_rdat;
  logic          busy;
  logic          error;
  logic          run_done;
  logic [CW-1:0] run_cycles;

  modport master (
    input  start, ld_count, rs_base, rs_count, ld_valid, ld_data, rs_ready, core_done, mem_rdat,
    output ld_ready, rs_valid, rs_data, core_reset, mem_sel, mem_addr, mem_wdat, mem_we,
           busy, error, run_done, run_cycles
  );

  modport slave (
    output start, ld_count, rs_base, rs_count, ld_valid, ld_data, rs_ready, core_done, mem_rdat,
    input  ld_ready, rs_valid, rs_data, core_reset, mem_sel, mem_addr, mem_wdat, mem_we,
           busy, error, run_done, run_cycles
  );

endinterface

// File: rtl/xfer_counter.sv
// Beat index shared by the preload and result-drain phases.
// One bit wider than the address so a full-memory transfer can be counted.
module xfer_counter import run_seq_pkg::*; #(
  parameter int unsigned AW = DefAw
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [AW:0]   target_i,
  output logic [AW-1:0] idx_o,
  output logic          last_o
);

  logic [AW:0] idx_q, idx_d;

  // Clear wins over increment.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + (AW+1)'(1);
    end
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q[AW-1:0];
  assign last_o = ((idx_q + (AW+1)'(1)) == target_i);

endmodule

// File: rtl/run_sequencer.sv
// Preloads data memory, runs the core until done or timeout, then drains a
// result window back to the host.
module run_sequencer import run_seq_pkg::*; #(
  parameter int unsigned AW      = DefAw,
  parameter int unsigned CW      = DefCw,
  parameter int unsigned MAX_CYC = DefMaxCyc
) (
  input logic       clk,
  input logic       reset,
  run_seq_if.master bus
);

  localparam logic [CW-1:0] MaxCycM1 = CW'(MAX_CYC - 1);

  seq_state_t    state_q, state_d;
  logic [AW:0]   ld_count_q, rs_count_q;
  logic [AW-1:0] rs_base_q;
  logic [CW-1:0] run_cycles_q, run_cycles_d;
  logic          error_q, error_d;
  logic          run_done_q, run_done_d;
  logic          latch_en;
  logic          cnt_clr, cnt_inc, cnt_last;
  logic [AW:0]   cnt_target;
  logic [AW-1:0] cnt_idx;

  assign cnt_target = (state_q == StDrain) ? rs_count_q : ld_count_q;

  xfer_counter #(
    .AW (AW)
  ) u_xfer_counter (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (cnt_clr),
    .inc_i    (cnt_inc),
    .target_i (cnt_target),
    .idx_o    (cnt_idx),
    .last_o   (cnt_last)
  );

  // Next-state, counter control and status updates.
  always_comb begin
    state_d      = state_q;
    run_cycles_d = run_cycles_q;
    error_d      = error_q;
    run_done_d   = 1'b0;
    latch_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state_q)
      StIdle, StErr: begin
        if (bus.start) begin
          latch_en     = 1'b1;
          cnt_clr      = 1'b1;
          error_d      = 1'b0;
          run_cycles_d = '0;
          state_d      = (bus.ld_count == '0) ? StRun : StLoad;
        end
      end
      StLoad: begin
        if (bus.ld_valid) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        run_cycles_d = run_cycles_q + CW'(1);
        // run_cycles_q is zero only in the first RUN cycle, while the core leaves reset.
        if ((run_cycles_q != '0) && bus.core_done) begin
          if (rs_count_q == '0) begin
            state_d    = StIdle;
            run_done_d = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end else if (run_cycles_q == MaxCycM1) begin
          state_d = StErr;
          error_d = 1'b1;
        end
      end
      StDrain: begin
        if (bus.rs_ready) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d    = StIdle;
            run_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, status and latched run parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      run_cycles_q <= '0;
      error_q      <= 1'b0;
      run_done_q   <= 1'b0;
      ld_count_q   <= '0;
      rs_count_q   <= '0;
      rs_base_q    <= '0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      error_q      <= error_d;
      run_done_q   <= run_done_d;
      if (latch_en) begin
        ld_count_q <= bus.ld_count;
        rs_count_q <= bus.rs_count;
        rs_base_q  <= bus.rs_base;
      end
    end
  end

  // Outputs decoded from state; only mem_we and rs_data see inputs combinationally.
  always_comb begin
    bus.busy       = 1'b0;
    bus.core_reset = 1'b1;
    bus.mem_sel    = 1'b1;
    bus.ld_ready   = 1'b0;
    bus.rs_valid   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdat   = '0;
    bus.mem_we     = 1'b0;
    bus.rs_data    = '0;
    unique case (state_q)
      StLoad: begin
        bus.busy     = 1'b1;
        bus.ld_ready = 1'b1;
        bus.mem_addr = cnt_idx;
        bus.mem_wdat = bus.ld_data;
        bus.mem_we   = bus.ld_valid;
      end
      StRun: begin
        bus.busy       = 1'b1;
        bus.core_reset = 1'b0;
        bus.mem_sel    = 1'b0;
      end
      StDrain: begin
        bus.busy     = 1'b1;
        bus.rs_valid = 1'b1;
        // Wraps past the top of memory.
        bus.mem_addr = rs_base_q + cnt_idx;
        bus.rs_data  = bus.mem_rdat;
      end
      default: ;
    endcase
  end

  assign bus.error      = error_q;
  assign bus.run_done   = run_done_q;
  assign bus.run_cycles = run_cycles_q;

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Sequences one program run of the single-cycle core. The block preloads data memory from a host byte stream while holding the core in reset, then releases the core and counts cycles until `done`. It then streams a result window of data memory back to the host. It owns the data-memory write/address port whenever the core is not running; a top-level mux selects between it and the core using `mem_sel`.

## Interface
- `AW`, 8: data-memory address width; memory is 2^AW bytes.
- `CW`, 16: width of the run-cycle counter.
- `MAX_CYC`, 16'hFFFF: cycle budget for one run; reaching it without `core_done` is a timeout.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a run; sampled only in IDLE or ERR.
- `ld_count` in AW+1: number of bytes to preload (0..2^AW); latched on an accepted `start`.
- `rs_base` in AW: first result address; latched on an accepted `start`.
- `rs_count` in AW+1: number of result bytes; latched on an accepted `start`.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 8: preload stream, valid/ready.
- `rs_valid` out 1, `rs_ready` in 1, `rs_data` out 8: result stream, valid/ready.
- `core_reset` out 1: active-high reset to the core (PC, flags).
- `core_done` in 1: the core's `done`.
- `mem_sel` out 1: 1 = sequencer drives data memory; 0 = core drives it.
- `mem_addr` out AW, `mem_wdat` out 8, `mem_we` out 1: sequencer memory port.
- `mem_rdat` in 8: data-memory read data; combinational from `mem_addr`.
- `busy` out 1: state is not IDLE and not ERR.
- `error` out 1: timeout occurred; cleared by the next accepted `start`.
- `run_done` out 1: one-cycle pulse when DRAIN completes.
- `run_cycles` out CW: cycles spent in RUN for the current or last run.

## Operation
- States:
  - IDLE: the reset state.
  - LOAD: preload data memory from the host stream.
  - RUN: the core executes.
  - DRAIN: stream the result window to the host.
  - ERR: a run timed out.
- Reset values: state IDLE, `core_reset`=1, `mem_sel`=1, `mem_we`=0, `ld_ready`=0, `rs_valid`=0, `busy`=0, `error`=0, `run_done`=0, `run_cycles`=0, beat index 0.
- IDLE/ERR with `start`=1:
  - Latch `ld_count`, `rs_base`, `rs_count`; clear `error`, `run_cycles` and the beat index.
  - Go to LOAD; if `ld_count`=0, go directly to RUN.
- LOAD:
  - `ld_ready`=1; `mem_addr` = beat index; `mem_wdat` = `ld_data`.
  - `mem_we` = `ld_valid` & `ld_ready` (combinational).
  - Each handshake increments the beat index.
  - On the handshake for beat `ld_count`-1: go to RUN and clear the index.
- RUN:
  - `core_reset`=0, `mem_sel`=0, `ld_ready`=0; `run_cycles` increments every cycle.
  - `core_done` is ignored in the first RUN cycle, because the core is still leaving reset.
  - After the first cycle, `core_done`=1 leads to DRAIN, or to IDLE with a `run_done` pulse if `rs_count`=0.
  - If `run_cycles`==MAX_CYC-1 and `core_done`=0: go to ERR and set `error`=1.
  - `core_done` on that same cycle wins: done has priority over timeout.
- DRAIN:
  - `core_reset`=1, `mem_sel`=1.
  - `mem_addr` = (`rs_base` + index) mod 2^AW, wrapping past the top of memory.
  - `rs_valid`=1; `rs_data` = `mem_rdat`.
  - Each `rs_valid`&`rs_ready` increments the index.
  - On the last beat: go to IDLE and pulse `run_done`.
- ERR: `core_reset`=1, `mem_sel`=1; the machine holds until `start`.
- `start` is ignored in LOAD, RUN and DRAIN.
- `ld_count` = 2^AW fills all of memory; the beat index is AW+1 bits wide.
- Asynchronous reset mid-operation returns every output to its reset value immediately. A partial load is not rolled back.

## Timing
- `start` sampled at edge N: LOAD is visible (`ld_ready`=1) in cycle N+1.
- LOAD accepts one byte per cycle; the memory write happens on the same edge as the handshake.
- The last LOAD handshake at edge M: `core_reset`=0 from cycle M+1, so the core's first instruction executes at edge M+2.
- `run_cycles` after a run equals the number of RUN cycles, including the cycle in which done was seen.
- DRAIN delivers one byte per cycle under constant `rs_ready`.
- `rs_data` stays stable while `rs_valid` & !`rs_ready`: the address is held.
- `busy`, `core_reset`, `mem_sel`, `ld_ready`, `rs_valid` are decoded from the state register only, with no input-to-output combinational path.
- Combinational paths exist only for `mem_we` (from `ld_valid`) and `rs_data` (from `mem_rdat`).

## Structure
- Package `run_seq_pkg`: the `seq_state_t` enum (IDLE, LOAD, RUN, DRAIN, ERR) and default constants for AW, CW and MAX_CYC.
- One sub-module, `xfer_counter`: an AW+1-bit beat index with clear, increment and a last-beat compare against a target count. It is shared by LOAD and DRAIN because those states are mutually exclusive.
- The FSM, the cycle counter and the address adder live in `run_sequencer`.

## Test plan
- Reset with `reset`=0, then release → `core_reset`=1, `mem_sel`=1, `busy`=0, all valids/readies 0.
- `start` with `ld_count`=3, bytes 0x11/0x22/0x33, `ld_valid` gapped every other cycle → `mem_we` only on handshakes; memory 0..2 holds 11,22,33; RUN entered after the third beat.
- Core model asserts `core_done` 10 cycles into RUN; `rs_base`=0xFE, `rs_count`=4 → addresses FE,FF,00,01 in order; `rs_ready` toggling stalls with stable `rs_data`; `run_done` pulse; `run_cycles`=10.
- `ld_count`=0, `rs_count`=0 → IDLE→RUN directly; after done, straight to IDLE with a `run_done` pulse and no `rs_valid`.
- MAX_CYC=8, `core_done` never asserted → ERR after 8 RUN cycles with `error`=1 and `core_reset`=1. A following `start` clears `error` and reaches LOAD.
- `reset` asserted in the middle of DRAIN → outputs return to their reset values asynchronously; after release, a new `start` works normally.
